// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the IF-stage address and buffers fetched {pc, instruction} pairs in a FIFO.
// Define FETCH_SEQ_STATS_EN to add the fetch_count / stall_count statistics outputs.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd8,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] pc,
  input  logic [63:0] pc_next,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_SEQ_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {START, FETCH} state_t;

  state_t             state, state_nxt;
  logic [63:0]        pc_nxt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [63:0]        pc_mem    [DEPTH];
  logic [31:0]        instr_mem [DEPTH];
  logic [63:0]        redirect_aligned;
  logic               full, pop, push, stall, flush;

  assign full             = (count == CNT_W'(DEPTH));
  assign out_valid        = (count != '0);
  assign pop              = out_valid && out_ready;
  assign redirect_aligned = redirect_pc & ~64'd3;
  assign out_pc           = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_instr        = out_valid ? instr_mem[rd_ptr] : '0;

  // NOTE: every signal gets a default before any branch so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    if (redirect_valid) begin
      flush     = 1'b1;
      state_nxt = FETCH;
      pc_nxt    = redirect_aligned;
    end else begin
      case (state)
        START: state_nxt = FETCH;
        FETCH: begin
          if (!full || pop) begin
            push   = 1'b1;
            pc_nxt = pc_next;
          end else begin
            stall = 1'b1;
          end
        end
        default: state_nxt = START;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= START;
      pc     <= RESET_PC;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // NOTE: storage is not reset; count gates out_valid and the head outputs, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= instruction;
    end
  end

`ifdef FETCH_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push)  fetch_count <= fetch_count + 32'd1;
      if (stall) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the fetch pipeline.
module tb_fetch_sequencer;

  localparam logic [63:0] RESET_PC = 64'd8;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc, pc_next, redirect_pc, out_pc;
  logic [31:0] instruction, out_instr;
  logic        redirect_valid, out_valid, out_ready;
`ifdef FETCH_SEQ_STATS_EN
  logic [31:0] fetch_count, stall_count;
`endif

  // IF-stage model: sequential address is pc + step, instruction derived from pc.
  logic [63:0] step = 64'd4;
  logic [31:0] salt = 32'd0;
  assign pc_next     = pc + step;
  assign instruction = pc[31:0] ^ salt;

  fetch_sequencer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .pc_next        (pc_next),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_SEQ_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of fetched entries, the next fetch address and two counters.
  logic [63:0] q_pc  [$];
  logic [31:0] q_ins [$];
  logic [63:0] m_pc;
  bit          m_started;
  logic [31:0] m_fetch, m_stall;

  task automatic model_reset();
    q_pc.delete();
    q_ins.delete();
    m_pc      = RESET_PC;
    m_started = 1'b0;
    m_fetch   = '0;
    m_stall   = '0;
  endtask

  task automatic model_step(input logic rdy, input logic rv, input logic [63:0] rpc);
    if (rv) begin
      q_pc.delete();
      q_ins.delete();
      m_pc      = {rpc[63:2], 2'b00};
      m_started = 1'b1;
      return;
    end
    if (!m_started) begin
      m_started = 1'b1;
      return;
    end
    if (rdy && q_pc.size() > 0) begin
      void'(q_pc.pop_front());
      void'(q_ins.pop_front());
    end
    if (q_pc.size() < DEPTH) begin
      q_pc.push_back(m_pc);
      q_ins.push_back(m_pc[31:0] ^ salt);
      m_pc    = m_pc + step;
      m_fetch = m_fetch + 32'd1;
    end else begin
      m_stall = m_stall + 32'd1;
    end
  endtask

  // One clock: drive inputs, advance the model, then compare at the following falling edge.
  task automatic tick(input logic rdy, input logic rv, input logic [63:0] rpc);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model_step(rdy, rv, rpc);
    @(negedge clk);
    check("pc", pc, m_pc);
    check("out_valid", 64'(out_valid), 64'(q_pc.size() > 0));
    check("out_pc", out_pc, (q_pc.size() > 0) ? q_pc[0] : 64'd0);
    check("out_instr", 64'(out_instr), (q_ins.size() > 0) ? 64'(q_ins[0]) : 64'd0);
`ifdef FETCH_SEQ_STATS_EN
    check("fetch_count", 64'(fetch_count), 64'(m_fetch));
    check("stall_count", 64'(stall_count), 64'(m_stall));
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, pc, RESET_PC);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_pc"}, out_pc, 64'd0);
    check({tag, "_out_instr"}, 64'(out_instr), 64'd0);
`ifdef FETCH_SEQ_STATS_EN
    check({tag, "_fetch_count"}, 64'(fetch_count), 64'd0);
    check({tag, "_stall_count"}, 64'(stall_count), 64'd0);
`endif
  endtask

  // Called at a falling edge: reset for two cycles, then release away from the rising edge.
  task automatic do_reset();
    reset          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step           = 64'd4;
    salt           = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(negedge clk);
    do_reset();

    // Sequential fetch with the consumer always ready: START cycle, then 8, 12, 16.
    check("start_pc", pc, 64'd8);
    tick(1'b1, 1'b0, '0);
    check("start_valid", 64'(out_valid), 64'd0);
    tick(1'b1, 1'b0, '0);
    check("seq_0", out_pc, 64'd8);
    tick(1'b1, 1'b0, '0);
    check("seq_1", out_pc, 64'd12);
    tick(1'b1, 1'b0, '0);
    check("seq_2", out_pc, 64'd16);

    // Backpressure: five stalled FETCH cycles fill the queue with 8, 12 and hold pc at 16.
    do_reset();
    tick(1'b0, 1'b0, '0);
    repeat (5) tick(1'b0, 1'b0, '0);
    check("full_head", out_pc, 64'd8);
    check("full_pc", pc, 64'd16);
`ifdef FETCH_SEQ_STATS_EN
    check("full_fetch_count", 64'(fetch_count), 64'd2);
    check("full_stall_count", 64'(stall_count), 64'd3);
`endif
    tick(1'b1, 1'b0, '0);
    check("drain_0", out_pc, 64'd12);
    tick(1'b1, 1'b0, '0);
    check("drain_1", out_pc, 64'd16);
    tick(1'b1, 1'b0, '0);
    check("drain_2", out_pc, 64'd20);

    // Redirect with two entries queued: flush, low bits masked.
    do_reset();
    repeat (3) tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 64'h103);
    check("redir_valid", 64'(out_valid), 64'd0);
    check("redir_pc", pc, 64'h100);
    tick(1'b1, 1'b0, '0);
    check("redir_head", out_pc, 64'h100);

    // Redirect coinciding with a pop from a full queue; then back-to-back redirects.
    repeat (3) tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b1, 64'h207);
    check("redir_pop_valid", 64'(out_valid), 64'd0);
    check("redir_pop_pc", pc, 64'h204);
    tick(1'b1, 1'b1, 64'h300);
    tick(1'b1, 1'b1, 64'h40a);
    check("b2b_valid", 64'(out_valid), 64'd0);
    check("b2b_pc", pc, 64'h408);
    tick(1'b1, 1'b0, '0);
    check("b2b_head", out_pc, 64'h408);

    // Asynchronous reset asserted mid-cycle with entries queued.
    tick(1'b0, 1'b0, '0);
    @(posedge clk);
    #2;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clk);
    do_reset();
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    check("restart_0", out_pc, 64'd8);
    tick(1'b1, 1'b0, '0);
    check("restart_1", out_pc, 64'd12);

    // Randomized traffic: varied IF step, instruction pattern, backpressure and redirects.
    for (int i = 0; i < 400; i++) begin
      logic        rdy, rv;
      logic [63:0] rpc;
      case ($urandom_range(0, 3))
        0:       step = 64'd4;
        1:       step = 64'd8;
        2:       step = 64'd6;
        default: step = 64'd2;
      endcase
      salt = $urandom;
      rdy  = ($urandom_range(0, 3) != 0);
      rv   = ($urandom_range(0, 15) == 0);
      rpc  = {$urandom, $urandom};
      tick(rdy, rv, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
